// File: rtl/gpr_file_halt_ctrl.sv
// gpr_file_halt_ctrl: 32x64 register file with bypassed reads, commit tracking and ebreak->drain->halt sequencer
// Outputs form the producer side of the simulation-model snapshot interface.
module gpr_file_halt_ctrl #(
    parameter int XLEN         = 64,
    parameter int NREG         = 32,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(NREG)-1:0]  raddr1,
    input  logic [$clog2(NREG)-1:0]  raddr2,
    output logic [XLEN-1:0]          rdata1,
    output logic [XLEN-1:0]          rdata2,
    input  logic                     wen,
    input  logic [$clog2(NREG)-1:0]  waddr,
    input  logic [XLEN-1:0]          wdata,
    input  logic                     commit_valid,
    input  logic [31:0]              commit_pc,
    input  logic [31:0]              commit_inst,
    input  logic                     commit_ebreak,
    output logic                     is_break,
    output logic [XLEN-1:0]          halt_code,
    output logic [63:0]              retire_cnt,
    output logic [31:0]              dbg_pc,
    output logic [31:0]              dbg_inst,
    output logic [NREG*XLEN-1:0]     dbg_rf
);
    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;
    localparam int AW = $clog2(NREG);
    localparam logic [AW-1:0] A0_IDX = AW'(10);

    state_t          state;
    logic [3:0]      cnt;
    logic [XLEN-1:0] rf [NREG];
    logic            wr_ok;
    logic [XLEN-1:0] a0_val;

    assign wr_ok  = wen && waddr != '0 && state != HALT;
    assign rdata1 = raddr1 == '0 ? '0 : (wr_ok && waddr == raddr1) ? wdata : rf[raddr1];
    assign rdata2 = raddr2 == '0 ? '0 : (wr_ok && waddr == raddr2) ? wdata : rf[raddr2];
    assign a0_val = (wr_ok && waddr == A0_IDX) ? wdata : rf[A0_IDX];

    // rf[0] is reset to zero and never written, so slot 0 of the snapshot stays zero
    for (genvar i = 0; i < NREG; i++) begin : g_snap
        assign dbg_rf[i*XLEN +: XLEN] = rf[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
            state      <= RUN;
            cnt        <= '0;
            is_break   <= 1'b0;
            halt_code  <= '0;
            retire_cnt <= '0;
            dbg_pc     <= '0;
            dbg_inst   <= '0;
        end else begin
            if (wr_ok) rf[waddr] <= wdata;
            is_break <= state == HALT;
            if (state == RUN && commit_valid) begin
                retire_cnt <= retire_cnt + 64'd1;
                dbg_pc     <= commit_pc;
                dbg_inst   <= commit_inst;
                if (commit_ebreak) begin
                    halt_code <= a0_val;
                    cnt       <= 4'(DRAIN_CYCLES);
                    state     <= DRAIN_CYCLES == 0 ? HALT : DRAIN;
                end
            end else if (state == DRAIN) begin
                cnt   <= cnt - 4'd1;
                state <= cnt <= 4'd1 ? HALT : DRAIN;
            end
        end
    end
endmodule

// File: tb/tb_gpr_file_halt_ctrl.sv
// tb_gpr_file_halt_ctrl: directed vectors for the register file, bypass and halt sequencer.
module tb_gpr_file_halt_ctrl;
    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    raddr1, raddr2, waddr;
    logic [63:0]   rdata1, rdata2, wdata;
    logic          wen;
    logic          commit_valid, commit_ebreak;
    logic [31:0]   commit_pc, commit_inst;
    logic          is_break;
    logic [63:0]   halt_code, retire_cnt;
    logic [31:0]   dbg_pc, dbg_inst;
    logic [2047:0] dbg_rf;
    int            checks = 0;
    int            errors = 0;

    gpr_file_halt_ctrl dut (
        .clk(clk), .rst(rst),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
        .wen(wen), .waddr(waddr), .wdata(wdata),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_inst(commit_inst),
        .commit_ebreak(commit_ebreak),
        .is_break(is_break), .halt_code(halt_code), .retire_cnt(retire_cnt),
        .dbg_pc(dbg_pc), .dbg_inst(dbg_inst), .dbg_rf(dbg_rf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] snap(input int r);
        return dbg_rf[r*64 +: 64];
    endfunction

    task automatic idle();
        wen = 0; waddr = 0; wdata = 0;
        commit_valid = 0; commit_ebreak = 0; commit_pc = 0; commit_inst = 0;
    endtask

    initial begin
        rst = 1; raddr1 = 0; raddr2 = 0;
        idle();
        step(); step();
        rst = 0;
        // run a little, then reset mid-run
        wen = 1; waddr = 3; wdata = 64'h11;
        commit_valid = 1; commit_pc = 32'h100; commit_inst = 32'h13;
        step();
        idle();
        chk("pre_rst_retire", retire_cnt, 1);
        chk("pre_rst_pc", {32'h0, dbg_pc}, 64'h100);
        chk("pre_rst_x3", snap(3), 64'h11);
        #2 rst = 1;
        #1;
        chk("rst_retire", retire_cnt, 0);
        chk("rst_pc", {32'h0, dbg_pc}, 0);
        chk("rst_inst", {32'h0, dbg_inst}, 0);
        chk("rst_x3", snap(3), 0);
        chk("rst_brk", {63'h0, is_break}, 0);
        chk("rst_halt_code", halt_code, 0);
        step();
        rst = 0;
        // write / read
        wen = 1; waddr = 5; wdata = 64'hDEAD_BEEF;
        step();
        wen = 0; raddr1 = 5;
        #1 chk("rd_x5", rdata1, 64'hDEAD_BEEF);
        wen = 1; waddr = 0; wdata = 64'h1234; raddr1 = 0;
        #1 chk("rd_x0_bypass", rdata1, 0);
        step();
        wen = 0;
        chk("rd_x0", rdata1, 0);
        chk("snap_x0", snap(0), 0);
        // bypass
        wen = 1; waddr = 7; wdata = 64'h55; raddr2 = 7;
        #1 chk("byp_rd2", rdata2, 64'h55);
        chk("byp_snap_pre", snap(7), 0);
        step();
        wen = 0;
        chk("byp_snap_post", snap(7), 64'h55);
        chk("byp_rd2_post", rdata2, 64'h55);
        // halt sequence
        wen = 1; waddr = 10; wdata = 64'h2A;
        step();
        idle();
        commit_valid = 1; commit_pc = 32'h200; commit_inst = 32'h13;
        step();
        commit_pc = 32'h204; commit_inst = 32'h0010_0073; commit_ebreak = 1;
        step();                      // edge N
        idle();
        chk("brk_n", {63'h0, is_break}, 0);
        chk("halt_code", halt_code, 64'h2A);
        chk("brk_retire", retire_cnt, 2);
        chk("brk_pc", {32'h0, dbg_pc}, 64'h204);
        commit_valid = 1; commit_pc = 32'h300; wen = 1; waddr = 12; wdata = 64'h99;
        step();                      // N+1, drain: commit ignored, write kept
        idle();
        chk("drain_retire", retire_cnt, 2);
        chk("drain_pc", {32'h0, dbg_pc}, 64'h204);
        chk("drain_x12", snap(12), 64'h99);
        chk("brk_n1", {63'h0, is_break}, 0);
        step();                      // N+2
        chk("brk_n2", {63'h0, is_break}, 0);
        step();                      // N+3
        chk("brk_n3", {63'h0, is_break}, 1);
        // post-halt freeze
        wen = 1; waddr = 5; wdata = 64'h777; raddr1 = 5;
        commit_valid = 1; commit_ebreak = 1; commit_pc = 32'h400;
        #1 chk("halt_no_byp", rdata1, 64'hDEAD_BEEF);
        step();
        step();
        idle();
        chk("halt_x5", snap(5), 64'hDEAD_BEEF);
        chk("halt_retire", retire_cnt, 2);
        chk("halt_pc", {32'h0, dbg_pc}, 64'h204);
        chk("halt_code_frz", halt_code, 64'h2A);
        chk("halt_sticky", {63'h0, is_break}, 1);
        #2 rst = 1;
        #1;
        chk("rst2_brk", {63'h0, is_break}, 0);
        chk("rst2_retire", retire_cnt, 0);
        step();
        rst = 0;
        commit_valid = 1; commit_pc = 32'h500;
        step();
        idle();
        chk("run_retire", retire_cnt, 1);
        chk("run_pc", {32'h0, dbg_pc}, 64'h500);
        // ebreak with same-cycle x10 write
        wen = 1; waddr = 10; wdata = 64'h9;
        step();
        wdata = 64'h7;
        commit_valid = 1; commit_ebreak = 1; commit_pc = 32'h600;
        step();
        idle();
        chk("byp_halt_code", halt_code, 64'h7);
        step(); step();
        chk("byp_brk_n2", {63'h0, is_break}, 0);
        step();
        chk("byp_brk_n3", {63'h0, is_break}, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
